// File: rtl/rvc_asap_5pl_i_mem_ctrl.sv
// Instruction-memory access controller: arbitrates the single I_MEM port between core fetch and host loader,
// sequences BOOT -> RUN and bounds host starvation. Define RVC_IMEM_CTRL_PERF_EN to add grant/stall counters.
module rvc_asap_5pl_i_mem_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 8,
    parameter bit BOOT_HOLD  = 1'b1
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic              FetchReq,
    input  logic [31:0]       FetchPc,
    output logic              FetchValid,
    output logic [31:0]       FetchInstr,
    output logic              FetchErr,
    output logic              CoreStall,
    input  logic              HostReq,
    input  logic              HostWr,
    input  logic [31:0]       HostAddr,
    input  logic [31:0]       HostWrData,
    input  logic [3:0]        HostByteEn,
    output logic              HostGnt,
    output logic              HostRdValid,
    output logic [31:0]       HostRdData,
    output logic              HostErr,
    input  logic              HostLoadDone,
    output logic [ADDR_W-3:0] MemAddr,
    output logic              MemWrEn,
    output logic [3:0]        MemByteEn,
    output logic [31:0]       MemWrData,
`ifdef RVC_IMEM_CTRL_PERF_EN
    output logic [31:0]       PerfFetchCnt,
    output logic [31:0]       PerfHostCnt,
    output logic [31:0]       PerfStallCnt,
`endif
    input  logic [31:0]       MemRdData
);

    typedef enum logic {BOOT, RUN} state_t;

    localparam state_t RST_STATE = BOOT_HOLD ? BOOT : RUN;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t state_q, state_d;
    logic [CNT_W-1:0] starve_q;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic fetch_gnt, host_gnt, host_wins, stall;
    logic fetch_bad, host_bad;
    logic fv_q, fe_q, hv_q, he_q;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> ADDR_W) != 32'd0);
    endfunction

    assign fetch_bad = addr_bad(FetchPc);
    assign host_bad  = addr_bad(HostAddr);

    // Arbitration and boot sequencing; nothing is granted while reset is asserted
    always_comb begin
        state_d   = state_q;
        fetch_gnt = 1'b0;
        host_gnt  = 1'b0;
        host_wins = 1'b0;
        stall     = 1'b0;
        case (state_q)
            BOOT: begin
                stall    = 1'b1;
                host_gnt = HostReq;
                if (HostLoadDone) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                host_wins = HostReq && (!FetchReq || (starve_q == STARVE_LIM));
                host_gnt  = host_wins;
                fetch_gnt = FetchReq && !host_wins;
                stall     = FetchReq && host_wins;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase
        if (Rst) begin
            fetch_gnt = 1'b0;
            host_gnt  = 1'b0;
            stall     = stall || FetchReq;
        end
    end

    assign CoreStall = stall;
    assign HostGnt   = host_gnt;

    // Erroring accesses are granted but leave the memory address untouched
    always_comb begin
        addr_d    = addr_q;
        MemWrEn   = 1'b0;
        MemByteEn = 4'b0000;
        MemWrData = 32'd0;
        if (fetch_gnt && !fetch_bad) begin
            addr_d = FetchPc[ADDR_W-1:2];
        end else if (host_gnt && !host_bad) begin
            addr_d = HostAddr[ADDR_W-1:2];
            if (HostWr) begin
                MemWrEn   = 1'b1;
                MemByteEn = HostByteEn;
                MemWrData = HostWrData;
            end
        end
    end

    assign MemAddr = addr_d;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_q  <= RST_STATE;
            starve_q <= '0;
            addr_q   <= '0;
            fv_q     <= 1'b0;
            fe_q     <= 1'b0;
            hv_q     <= 1'b0;
            he_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            fv_q    <= fetch_gnt;
            fe_q    <= fetch_gnt && fetch_bad;
            hv_q    <= host_gnt && !HostWr;
            he_q    <= host_gnt && host_bad;
            if (host_gnt) begin
                starve_q <= '0;
            end else if (HostReq && (starve_q != STARVE_LIM)) begin
                starve_q <= starve_q + 1'b1;
            end
        end
    end

    // Responses are masked during reset so an in-flight access is dropped immediately
    assign FetchValid  = fv_q && !Rst;
    assign FetchErr    = fe_q && !Rst;
    assign FetchInstr  = (FetchValid && !fe_q) ? MemRdData : 32'd0;
    assign HostRdValid = hv_q && !Rst;
    assign HostErr     = he_q && !Rst;
    assign HostRdData  = (HostRdValid && !he_q) ? MemRdData : 32'd0;

`ifdef RVC_IMEM_CTRL_PERF_EN
    always_ff @(posedge Clock) begin
        if (Rst) begin
            PerfFetchCnt <= 32'd0;
            PerfHostCnt  <= 32'd0;
            PerfStallCnt <= 32'd0;
        end else begin
            if (fetch_gnt) begin
                PerfFetchCnt <= PerfFetchCnt + 32'd1;
            end
            if (host_gnt) begin
                PerfHostCnt <= PerfHostCnt + 32'd1;
            end
            if ((state_q == RUN) && stall) begin
                PerfStallCnt <= PerfStallCnt + 32'd1;
            end
        end
    end
`endif

endmodule
